// File: rtl/aes_pkg.sv
// Shared types for the AES-128 byte-stream feeder: block/key types and the feeder FSM states.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [127:0] aes_block_t;
  typedef logic [127:0] aes_key_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/aes_byte_shifter.sv
// 128-bit byte shift register with clear, parallel load, left byte shift and a 4-bit byte count.
// Used both as serial-in/parallel-out (input side) and parallel-in/serial-out (output side).
module aes_byte_shifter
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  aes_block_t load_data,
  input  logic       shift,
  input  logic [7:0] byte_in,
  output aes_block_t data,
  output logic [3:0] cnt
);

  aes_block_t data_q, data_d;
  logic [3:0] cnt_q, cnt_d;

  // Next-state: clear beats load beats shift; a byte enters at the bottom and walks to the top.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr) begin
      data_d = '0;
      cnt_d  = 4'd0;
    end else if (load) begin
      data_d = load_data;
      cnt_d  = 4'd0;
    end else if (shift) begin
      data_d = {data_q[119:0], byte_in};
      cnt_d  = cnt_q + 4'd1;
    end else begin
      data_d = data_q;
      cnt_d  = cnt_q;
    end
  end

  // Shift register and count state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= 4'd0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data = data_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/aes_stream_feeder.sv
// Byte-stream front/back end for the AES-128 encryptor core (FILL -> START -> WAIT -> DRAIN).
// Optional CBC chaining is enabled by defining AES_FEEDER_CBC_EN; default build is ECB.
module aes_stream_feeder
  import aes_pkg::*;
#(
  parameter int ENC_TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic [127:0] iv_in,
  input  logic         key_load,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [7:0]   m_data,
  output logic         m_last,
  output logic         enc_start,
  output logic [127:0] enc_data,
  output logic [127:0] enc_key,
  input  logic         enc_ready,
  input  logic [127:0] enc_cipher,
  output logic         busy,
  output logic         err
);

  localparam int WCW = (ENC_TIMEOUT > 2) ? $clog2(ENC_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(ENC_TIMEOUT - 1);

  feeder_state_e  state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  aes_key_t       key_q, key_d;
  logic           err_q, err_d;
  logic           s_ready_q, s_ready_d;
  logic           m_valid_q, m_valid_d;
  logic           busy_q, busy_d;
  logic           enc_start_q, enc_start_d;

  aes_block_t     in_data, out_data;
  logic [3:0]     in_cnt, out_cnt;
  logic           in_clr, out_load;
  logic           s_hs, m_hs, key_take, capture;
  logic           unused_s;

  assign s_hs     = s_valid && s_ready_q;
  assign m_hs     = m_valid_q && m_ready;
  assign key_take = (state_q == FILL) && (in_cnt == 4'd0) && key_load;
  assign capture  = (state_q == WAIT) && enc_ready;

  aes_byte_shifter u_in_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (in_clr),
    .load      (1'b0),
    .load_data ('0),
    .shift     (s_hs),
    .byte_in   (s_data),
    .data      (in_data),
    .cnt       (in_cnt)
  );

  aes_byte_shifter u_out_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (1'b0),
    .load      (out_load),
    .load_data (enc_cipher),
    .shift     (m_hs),
    .byte_in   (8'h00),
    .data      (out_data),
    .cnt       (out_cnt)
  );

  // Next-state logic; the wait counter also runs during START so the timeout lands ENC_TIMEOUT cycles after it.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    in_clr     = 1'b0;
    out_load   = 1'b0;
    if (key_take) begin
      key_d = key_in;
    end else begin
      key_d = key_q;
    end
    case (state_q)
      FILL: begin
        if (s_hs && (in_cnt == 4'd15)) begin
          state_d    = START;
          wait_cnt_d = '0;
        end else begin
          state_d = FILL;
        end
      end
      START: begin
        state_d    = WAIT;
        wait_cnt_d = wait_cnt_q + WCW'(1);
      end
      WAIT: begin
        if (enc_ready) begin
          state_d  = DRAIN;
          out_load = 1'b1;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = FILL;
          err_d   = 1'b1;
          in_clr  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      DRAIN: begin
        if (m_hs && (out_cnt == 4'd15)) begin
          state_d = FILL;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
    s_ready_d   = (state_d == FILL);
    m_valid_d   = (state_d == DRAIN);
    busy_d      = (state_d != FILL);
    enc_start_d = (state_d == START);
  end

  // FSM state, key, sticky error and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wait_cnt_q  <= '0;
      key_q       <= '0;
      err_q       <= 1'b0;
      s_ready_q   <= 1'b1;
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      enc_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      key_q       <= key_d;
      err_q       <= err_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      busy_q      <= busy_d;
      enc_start_q <= enc_start_d;
    end
  end

`ifdef AES_FEEDER_CBC_EN
  aes_block_t chain_q, chain_d;

  // Chain register: IV on an honoured key load, ciphertext on capture; a timeout leaves it alone.
  always_comb begin
    if (key_take) begin
      chain_d = iv_in;
    end else if (capture) begin
      chain_d = enc_cipher;
    end else begin
      chain_d = chain_q;
    end
  end

  // Chain register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign enc_data = in_data ^ chain_q;
  assign unused_s = ^out_data[119:0];
`else
  assign enc_data = in_data;
  assign unused_s = ^{out_data[119:0], iv_in};
`endif

  assign enc_key   = key_q;
  assign enc_start = enc_start_q;
  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign m_data    = out_data[127:120];
  assign m_last    = m_valid_q && (out_cnt == 4'd15);

endmodule

// File: tb/tb_aes_stream_feeder.sv
// Directed, table-driven bench for aes_stream_feeder (ECB build) with a behavioural core model.
module tb_aes_stream_feeder;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2     = 128'hfedcba9876543210f0e1d2c3b4a59687;
  localparam logic [127:0] PT2      = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam int           CORE_LAT = 11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] key_in = '0;
  logic [127:0] iv_in = '0;
  logic         key_load = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [7:0]   s_data = 8'h00;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [7:0]   m_data;
  logic         m_last;
  logic         enc_start;
  logic [127:0] enc_data;
  logic [127:0] enc_key;
  logic         enc_ready = 1'b0;
  logic [127:0] enc_cipher = '0;
  logic         busy;
  logic         err;

  int checks = 0;
  int failures = 0;

  aes_stream_feeder #(.ENC_TIMEOUT(32)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .iv_in(iv_in), .key_load(key_load),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .enc_start(enc_start), .enc_data(enc_data), .enc_key(enc_key),
    .enc_ready(enc_ready), .enc_cipher(enc_cipher), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Core stand-in: known FIPS-197 answer, otherwise a fixed key/data mix.
  function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] d);
    if (k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
    return {d[63:0], d[127:64]} ^ k ^ 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
  endfunction

  logic         core_dead = 1'b0;
  logic         core_busy = 1'b0;
  int           core_cnt = 0;
  logic [127:0] core_k = '0;
  logic [127:0] core_d = '0;

  // Behavioural core: samples on negedge like the real one, never reset by the feeder.
  always @(negedge clk) begin
    enc_ready <= 1'b0;
    if (enc_start && !core_busy) begin
      core_k    <= enc_key;
      core_d    <= enc_data;
      core_busy <= 1'b1;
      core_cnt  <= 0;
    end else if (core_busy) begin
      if (core_cnt == CORE_LAT - 1) begin
        core_busy  <= 1'b0;
        enc_ready  <= !core_dead;
        enc_cipher <= core_f(core_k, core_d);
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [127:0] pt;
    int           kl_at;
    logic [127:0] kl_key;
    bit           gap;
    bit           bp;
    logic [127:0] exp_key;
    logic [127:0] exp_ct;
  } vec_t;

  vec_t vecs[6];

  task automatic load_key(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  // Feeds 16 bytes; returns just after the edge that accepted the last one.
  task automatic send_block(input vec_t v);
    for (int i = 0; i < 16; i++) begin
      if (v.gap && $urandom_range(0, 1) == 1) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid  = 1'b1;
      s_data   = v.pt[127 - 8*i -: 8];
      key_load = (i == v.kl_at);
      if (i == v.kl_at) key_in = v.kl_key;
      @(negedge clk);
      chk("s_ready_fill", {127'd0, s_ready}, 128'd1);
      @(posedge clk); #1;
      s_valid  = 1'b0;
      key_load = 1'b0;
    end
  endtask

  task automatic expect_output(input vec_t v, input logic exp_err);
    int lat;
    int got;
    int cyc;
    logic held;
    logic [7:0] hold;
    @(negedge clk);
    chk("enc_start", {127'd0, enc_start}, 128'd1);
    chk("enc_data", enc_data, v.pt);
    chk("enc_key", enc_key, v.exp_key);
    lat = 0;
    while (m_valid !== 1'b1 && lat < 40) begin
      chk("s_ready_busy", {126'd0, s_ready, busy}, 128'd1);
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end
    chk("latency", 128'(lat), 128'(CORE_LAT + 1));
    @(posedge clk); #1;
    got = 0;
    cyc = 0;
    held = 1'b0;
    hold = 8'h00;
    while (got < 16 && cyc < 200) begin
      m_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (held) chk("m_data_hold", {120'd0, m_data}, {120'd0, hold});
      chk("m_valid_s_ready", {126'd0, m_valid, s_ready}, 128'd2);
      if (m_ready) begin
        chk("m_data", {120'd0, m_data}, {120'd0, v.exp_ct[127 - 8*got -: 8]});
        chk("m_last", {127'd0, m_last}, {127'd0, (got == 15)});
        got++;
        held = 1'b0;
      end else begin
        hold = m_data;
        held = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1'b0;
    chk("drain_count", 128'(got), 128'd16);
    @(negedge clk);
    chk("idle_after_block", {124'd0, m_valid, s_ready, busy, err}, {124'd0, 1'b0, 1'b1, 1'b0, exp_err});
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, {s_ready, m_valid, m_last, enc_start, busy, err, m_data},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    chk({name, "_enc"}, enc_data | enc_key, 128'd0);
  endtask

  initial begin
    vec_t tv;
    int lat;

    vecs[0] = '{FIPS_PT, -1, '0,       1'b0, 1'b0, FIPS_KEY, FIPS_CT};
    vecs[1] = '{FIPS_PT, -1, '0,       1'b1, 1'b1, FIPS_KEY, FIPS_CT};
    vecs[2] = '{PT2,      5, KEY2,     1'b0, 1'b0, FIPS_KEY, core_f(FIPS_KEY, PT2)};
    vecs[3] = '{FIPS_PT,  0, KEY2,     1'b1, 1'b0, KEY2,     core_f(KEY2, FIPS_PT)};
    vecs[4] = '{PT2,      0, FIPS_KEY, 1'b0, 1'b1, FIPS_KEY, core_f(FIPS_KEY, PT2)};
    vecs[5] = '{FIPS_PT, -1, '0,       1'b1, 1'b1, FIPS_KEY, FIPS_CT};

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_key(FIPS_KEY);

    for (int i = 0; i < 6; i++) begin
      send_block(vecs[i]);
      expect_output(vecs[i], 1'b0);
    end

    // Timeout: core never answers.
    core_dead = 1'b1;
    tv = vecs[0];
    send_block(tv);
    @(negedge clk);
    chk("to_enc_start", {127'd0, enc_start}, 128'd1);
    lat = 0;
    while (err !== 1'b1 && lat < 40) begin
      chk("to_no_m_valid", {127'd0, m_valid}, 128'd0);
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end
    chk("timeout_cycles", 128'(lat), 128'd32);
    chk("to_back_in_fill", {125'd0, m_valid, s_ready, busy}, {125'd0, 3'b010});
    @(posedge clk); #1;
    core_dead = 1'b0;
    send_block(tv);
    expect_output(tv, 1'b1);

    // Reset in the middle of WAIT.
    send_block(tv);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_wait");
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("no_output_after_reset", {126'd0, m_valid, busy}, 128'd0);
    end
    @(posedge clk); #1;
    load_key(FIPS_KEY);
    send_block(tv);
    expect_output(tv, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_stream_feeder.md
Name: aes_stream_feeder

Overview:
- Byte-stream front/back end for the AES-128 encryptor core.
- Assembles 16 input bytes into a 128-bit block, launches the core, captures the ciphertext when the core signals done, then serialises it out byte-wide.
- Sits directly upstream and downstream of the encryptor: drives its enable/data/key inputs and consumes its cipher/cipher_ready outputs.
- All logic is posedge clk. The core samples on negedge, so every output to the core is held stable for at least one full clk period.

Parameters:
ENC_TIMEOUT, 32, clk cycles to wait in WAIT for enc_ready before aborting the block and setting err.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
key_in  input  128  AES key, captured on key_load.
iv_in  input  128  CBC initial vector, captured on key_load; ignored unless AES_FEEDER_CBC_EN.
key_load  input  1  load key_in/iv_in.
s_valid  input  1  input byte valid.
s_ready  output  1  input byte accepted when s_valid && s_ready.
s_data  input  8  plaintext byte.
m_valid  output  1  output byte valid.
m_ready  input  1  downstream accepts byte.
m_data  output  8  ciphertext byte.
m_last  output  1  high with 16th byte of a block.
enc_start  output  1  to core enable_input.
enc_data  output  128  to core data.
enc_key  output  128  to core key.
enc_ready  input  1  from core cipher_ready.
enc_cipher  input  128  from core cipher.
busy  output  1  high in START/WAIT/DRAIN.
err  output  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (async, rst_n low) forces:
  - state FILL, byte count 0, key/iv/block registers 0, err 0.
  - Outputs: s_ready=1, m_valid=0, m_last=0, enc_start=0, busy=0; enc_data, enc_key and m_data all 0.
- FILL:
  - s_ready=1. Each handshake shifts s_data in; the first byte lands in bits [127:120].
  - 4-bit count increments per handshake. The 16th byte (count 15) moves to START.
- key_load:
  - Honoured only in FILL with count==0; ignored elsewhere.
  - If it coincides with a byte handshake at count 0, both take effect.
  - Under CBC_EN it also reloads the chain register with iv_in.
- START:
  - Exactly one cycle. enc_start=1; enc_data and enc_key are driven from the registers.
  - Wait counter is cleared; next state WAIT.
- WAIT:
  - enc_start=0. enc_data and enc_key are held stable until DRAIN is entered.
  - enc_ready sampled high at posedge: capture enc_cipher, go to DRAIN.
  - Wait counter reaches ENC_TIMEOUT-1 without enc_ready: set err, discard the block, go to FILL with count 0.
  - enc_ready is ignored in every other state.
- DRAIN:
  - s_ready=0, m_valid=1, m_data = cipher[127:120].
  - Each m_ready handshake shifts left 8 bits. m_last=1 on the 16th byte.
  - After the 16th handshake, go to FILL.
  - m_data/m_valid are held constant while m_ready=0.
- Latency: 1 cycle (START) + core latency, measured from the 16th input handshake to m_valid. With the current core this is 12-13 cycles.
- Reset mid-operation: the block in flight is dropped and nothing partial is emitted; the core is left to finish on its own.

Optional Feature:
AES_FEEDER_CBC_EN:
- Defined:
  - enc_data = assembled block XOR chain register.
  - The chain register is updated with each captured ciphertext.
  - The chain register is loaded from iv_in on key_load.
  - A timeout does not update the chain register.
- Undefined:
  - ECB mode: enc_data = assembled block.
  - iv_in is unused and there is no chain register.

Decomposition:
- Package aes_pkg:
  - AES_BLOCK_BYTES=16
  - typedef aes_block_t (128-bit)
  - typedef aes_key_t (128-bit)
  - state enum: FILL, START, WAIT, DRAIN
- One natural sub-module: aes_byte_shifter, a 128-bit shift register with load, byte shift and count. Instantiate it twice: serial-in/parallel-out for input, parallel-in/serial-out for output.

Test Plan:
- FIPS-197 vector in ECB (real core instance):
  - key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff.
  - Required: output bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a; m_last only on 5a; err=0.
- Back-pressure:
  - Same vector, m_ready toggled randomly and s_valid gapped.
  - Required: identical output bytes; m_data stable while m_ready=0; s_ready=0 throughout START/WAIT/DRAIN.
- Timeout:
  - Core replaced by a stub that never asserts enc_ready.
  - Required: err=1 exactly ENC_TIMEOUT cycles after START; state returns to FILL; no m_valid; next block with the real core completes normally.
- key_load gating:
  - key_load pulsed at count 5 with a different key.
  - Required: the key is not updated; the block encrypts under the old key.
  - Repeat with key_load at count 0 together with a byte handshake: the new key is used and the byte is accepted.
- Reset mid-WAIT:
  - rst_n low for 2 cycles during WAIT.
  - Required: all outputs at reset values immediately (async); no output bytes; the following FIPS vector block produces the correct ciphertext.
- CBC (macro defined):
  - iv 00112233445566778899aabbccddeeff, plaintext all 00, FIPS key.
  - Required: first output 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Second all-zero block must equal AES(key, 69c4...c55a).
